lr_predict: RTL

//  Inference stage downstream of the LR training core. Once training asserts fin, the trained

---
 rtl/lr_predict.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/lr_predict.sv
// Linear-regression inference stage: y_hat = w0 + sum(w_c*x_c) and residual per point,
// 1 point/cycle with valid/ready on both sides, plus a saturating batch SSE.
module lr_predict #(
   parameter int FEATURES = 6,
   parameter int FRAC     = 8,
   parameter int SSE_W    = 32
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       wt_load,
   input  logic [(FEATURES+1)*16-1:0] wt_in,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [(FEATURES+1)*16-1:0] s_data,
   input  logic                       s_last,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [15:0]                m_yhat,
   output logic [15:0]                m_err,
   output logic                       m_last,
   output logic [SSE_W-1:0]           sse,
   output logic                       sse_valid,
   output logic                       wt_ok
);
   localparam int W = (FEATURES+1)*16;
   // Each shifted product fits in 32-FRAC signed bits; extra headroom so the sum never wraps.
   localparam int SUM_W = 32 - FRAC + $clog2(FEATURES+2);
   localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'(32767);
   localparam logic signed [SUM_W-1:0] SAT_LO = SUM_W'(-32768);
   localparam logic [SSE_W:0] SSE_MAX = (SSE_W+1)'({(SSE_W-1){1'b1}});

   typedef enum logic [1:0] {NOWT, IDLE, RUN, FLUSH} state_t;

   function automatic logic [15:0] sat16(input logic signed [SUM_W-1:0] v);
      logic [15:0] r;
      if (v > SAT_HI)      r = 16'h7FFF;
      else if (v < SAT_LO) r = 16'h8000;
      else                 r = v[15:0];
      return r;
   endfunction

   state_t state_q, state_d;
   logic [W-1:0] wt_q, wt_d;
   logic wt_ok_q, wt_ok_d;
   logic v0_q, v0_d, last0_q, last0_d;
   logic [W-1:0] data0_q, data0_d;
   logic v1_q, v1_d, last1_q, last1_d;
   logic signed [31:0] prod_q [FEATURES];
   logic signed [31:0] prod_d [FEATURES];
   logic signed [15:0] y1_q, y1_d, bias1_q, bias1_d;
   logic v2_q, v2_d, last2_q, last2_d;
   logic signed [15:0] yhat2_q, yhat2_d, y2_q, y2_d;
   logic v3_q, v3_d, m_last_q, m_last_d;
   logic signed [15:0] m_yhat_q, m_yhat_d, m_err_q, m_err_d;
   logic [SSE_W-1:0] sse_q, sse_d;
   logic sse_valid_q, sse_valid_d;

   logic signed [31:0] prod_w [FEATURES];
   logic signed [SUM_W-1:0] sum_c, diff_c;
   logic signed [31:0] sq_c, sq_sh;
   logic [SSE_W:0] sse_add;
   logic adv, out_hs, load_ok, accept;

   for (genvar gi = 0; gi < FEATURES; gi++) begin : g_mul
      assign prod_w[gi] = 32'($signed(data0_q[16*(gi+1) +: 16])) *
                          32'($signed(wt_q[16*(gi+1) +: 16]));
   end

   always_comb begin
      sum_c = SUM_W'(bias1_q);
      for (int c = 0; c < FEATURES; c++) begin
         sum_c = sum_c + SUM_W'(prod_q[c] >>> FRAC);
      end
      diff_c  = SUM_W'(y2_q) - SUM_W'(yhat2_q);
      sq_c    = 32'(m_err_q) * 32'(m_err_q);
      sq_sh   = sq_c >>> FRAC;
      sse_add = {1'b0, sse_q} + (SSE_W+1)'($unsigned(sq_sh));
   end

   always_comb begin
      adv     = !v3_q || m_ready;
      out_hs  = v3_q && m_ready;
      load_ok = wt_load && (state_q == NOWT || state_q == IDLE);
      // A weight load in IDLE takes priority over an incoming beat.
      s_ready = adv && ((state_q == IDLE && !wt_load) || state_q == RUN);
      accept  = s_valid && s_ready;

      state_d = state_q;
      wt_d    = load_ok ? wt_in : wt_q;
      wt_ok_d = wt_ok_q | load_ok;
      v0_d = v0_q;   data0_d = data0_q; last0_d = last0_q;
      v1_d = v1_q;   prod_d  = prod_q;  y1_d = y1_q; bias1_d = bias1_q; last1_d = last1_q;
      v2_d = v2_q;   yhat2_d = yhat2_q; y2_d = y2_q; last2_d = last2_q;
      v3_d = v3_q;   m_yhat_d = m_yhat_q; m_err_d = m_err_q; m_last_d = m_last_q;
      sse_d       = sse_q;
      sse_valid_d = 1'b0;

      case (state_q)
         NOWT:    if (wt_load) state_d = IDLE;
         IDLE:    if (accept) state_d = s_last ? FLUSH : RUN;
         RUN:     if (accept && s_last) state_d = FLUSH;
         FLUSH:   if (out_hs && m_last_q) begin
                     state_d     = IDLE;
                     sse_valid_d = 1'b1;
                  end
         default: state_d = NOWT;
      endcase

      if (adv) begin
         v0_d = accept;  data0_d = s_data;  last0_d = s_last;
         v1_d = v0_q;    prod_d  = prod_w;
         y1_d = $signed(data0_q[15:0]);     bias1_d = $signed(wt_q[15:0]); last1_d = last0_q;
         v2_d = v1_q;    yhat2_d = sat16(sum_c); y2_d = y1_q; last2_d = last1_q;
         v3_d = v2_q;    m_yhat_d = yhat2_q; m_err_d = sat16(diff_c); m_last_d = last2_q;
      end

      if (accept && state_q == IDLE) sse_d = '0;
      else if (out_hs)               sse_d = (sse_add > SSE_MAX) ? SSE_MAX[SSE_W-1:0] : sse_add[SSE_W-1:0];
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= NOWT;        wt_q <= '0;           wt_ok_q <= 1'b0;
         v0_q <= 1'b0;           data0_q <= '0;        last0_q <= 1'b0;
         v1_q <= 1'b0;           prod_q <= '{default: '0};
         y1_q <= '0;             bias1_q <= '0;        last1_q <= 1'b0;
         v2_q <= 1'b0;           yhat2_q <= '0;        y2_q <= '0;      last2_q <= 1'b0;
         v3_q <= 1'b0;           m_yhat_q <= '0;       m_err_q <= '0;   m_last_q <= 1'b0;
         sse_q <= '0;            sse_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;     wt_q <= wt_d;         wt_ok_q <= wt_ok_d;
         v0_q <= v0_d;           data0_q <= data0_d;   last0_q <= last0_d;
         v1_q <= v1_d;           prod_q <= prod_d;
         y1_q <= y1_d;           bias1_q <= bias1_d;   last1_q <= last1_d;
         v2_q <= v2_d;           yhat2_q <= yhat2_d;   y2_q <= y2_d;    last2_q <= last2_d;
         v3_q <= v3_d;           m_yhat_q <= m_yhat_d; m_err_q <= m_err_d; m_last_q <= m_last_d;
         sse_q <= sse_d;         sse_valid_q <= sse_valid_d;
      end
   end

   assign m_valid   = v3_q;
   assign m_yhat    = m_yhat_q;
   assign m_err     = m_err_q;
   assign m_last    = m_last_q;
   assign sse       = sse_q;
   assign sse_valid = sse_valid_q;
   assign wt_ok     = wt_ok_q;
endmodule
